// File: rtl/tetris_pkg.sv
// Shared constants, grid type and line-clear FSM states for the tetris datapath.
package tetris_pkg;

  localparam int ROWS       = 22;               // row 0 = top, row ROWS-1 = bottom
  localparam int COLS       = 10;
  localparam int SPAWN_ROWS = 2;                // hidden rows a new piece spawns into
  localparam int ROW_W      = $clog2(ROWS);     // row pointer width
  localparam int CNT_W      = $clog2(ROWS + 1); // 0..ROWS rows removed per pass

  typedef logic [ROWS-1:0][COLS-1:0] grid_t;

  typedef enum logic [1:0] {
    LC_IDLE,
    LC_SCAN,
    LC_SHIFT,
    LC_DONE
  } lc_state_t;

endpackage

// File: rtl/grid_row_shift.sv
// Combinational row removal: drops row r, moves rows 0..r-1 down by one and
// zeroes row 0. Rows below r are passed through untouched.
module grid_row_shift
  import tetris_pkg::*;
(
  input  logic [ROWS-1:0][COLS-1:0] grid,
  input  logic [ROW_W-1:0]          r,
  output logic [ROWS-1:0][COLS-1:0] shifted
);

  // The top row always becomes empty, whatever row is removed.
  assign shifted[0] = '0;

  for (genvar i = 1; i < ROWS; i++) begin : g_row
    assign shifted[i] = (ROW_W'(i) <= r) ? grid[i-1] : grid[i];
  end

endmodule

// File: rtl/line_clear.sv
// Line clear engine: scans a merged grid bottom-up, removes every full row,
// compacts the rows above and reports per-pass and running line counts plus
// a sticky game-over flag when a spawn row is still occupied afterwards.
module line_clear
  import tetris_pkg::*;
#(
  parameter int TOTAL_W = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ROWS-1:0][COLS-1:0] grid_in,
  output logic [ROWS-1:0][COLS-1:0] grid_out,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          lines_cleared,
  output logic [TOTAL_W-1:0]        total_lines,
  output logic                      game_over
);

  localparam int                 SUM_W     = ((TOTAL_W > CNT_W) ? TOTAL_W : CNT_W) + 1;
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;

  lc_state_t      state;
  grid_t          work;
  grid_t          shifted;
  logic [ROW_W-1:0] r;
  logic [CNT_W-1:0] count;

  logic             scan_full;
  logic             shift_full;
  logic             enter_done;
  grid_t            final_grid;
  logic [CNT_W-1:0] final_count;
  logic [SUM_W-1:0] total_sum;
  logic [TOTAL_W-1:0] total_next;

  grid_row_shift u_shift (
    .grid    (work),
    .r       (r),
    .shifted (shifted)
  );

  assign scan_full  = &work[r];
  // In SHIFT the row that has just dropped into r is tested in the same
  // cycle, so each removed row costs exactly one extra cycle.
  assign shift_full = &shifted[r];

  assign busy = (state != LC_IDLE);
  assign done = (state == LC_DONE);

  // Decide whether this cycle ends the pass and what the final grid/count are.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    enter_done  = 1'b0;
    final_grid  = work;
    final_count = count;
    case (state)
      LC_SCAN: begin
        enter_done = !scan_full && (r == '0);
      end
      LC_SHIFT: begin
        final_grid  = shifted;
        final_count = count + CNT_W'(1);
        enter_done  = !shift_full && (r == '0);
      end
      default: ;
    endcase
    total_sum  = SUM_W'(total_lines) + SUM_W'(final_count);
    total_next = (total_sum > SUM_W'(TOTAL_MAX)) ? TOTAL_MAX : total_sum[TOTAL_W-1:0];
  end

  // Control FSM, row pointer, pass counter and registered results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= LC_IDLE;
      r             <= '0;
      count         <= '0;
      grid_out      <= '0;
      lines_cleared <= '0;
      total_lines   <= '0;
      game_over     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      case (state)
        LC_IDLE: begin
          if (start) begin
            state <= LC_SCAN;
            r     <= ROW_W'(ROWS - 1);
            count <= '0;
          end
        end
        LC_SCAN: begin
          if (scan_full)       state <= LC_SHIFT;
          else if (r == '0)    state <= LC_DONE;
          else                 r     <= r - ROW_W'(1);
        end
        LC_SHIFT: begin
          count <= count + CNT_W'(1);
          if (shift_full) begin
            state <= LC_SHIFT;
          end else if (r == '0) begin
            state <= LC_DONE;
          end else begin
            state <= LC_SCAN;
            r     <= r - ROW_W'(1);
          end
        end
        default: state <= LC_IDLE;
      endcase

      // Results land together with the done cycle and hold until the next pass ends.
      if (enter_done) begin
        grid_out      <= final_grid;
        lines_cleared <= final_count;
        total_lines   <= total_next;
        game_over     <= game_over | (|final_grid[SPAWN_ROWS-1:0]);
      end
    end
  end

  // Working copy of the grid: loaded on an accepted start, compacted in SHIFT.
  always_ff @(posedge clk) begin
    // NOTE: no reset on the work grid; it is always reloaded before it is read.
    if (state == LC_IDLE && start) work <= grid_in;
    else if (state == LC_SHIFT)    work <= shifted;
  end

endmodule

// File: tb/tb_line_clear.sv
// Scoreboard bench for line_clear: a reference compaction model pushes the
// expected pass result on each start; results are popped when done rises.
module tb_line_clear;
  import tetris_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      start;
  logic [ROWS-1:0][COLS-1:0] grid_in;

  logic [ROWS-1:0][COLS-1:0] grid_out, grid_out_s;
  logic                      busy, busy_s, done, done_s, game_over, game_over_s;
  logic [CNT_W-1:0]          lines_cleared, lines_cleared_s;
  logic [9:0]                total_lines;
  logic [2:0]                total_lines_s;

  line_clear #(.TOTAL_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .grid_in(grid_in),
    .grid_out(grid_out), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .total_lines(total_lines), .game_over(game_over)
  );

  line_clear #(.TOTAL_W(3)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .grid_in(grid_in),
    .grid_out(grid_out_s), .busy(busy_s), .done(done_s),
    .lines_cleared(lines_cleared_s), .total_lines(total_lines_s), .game_over(game_over_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    grid_t grid;
    int    lines;
    int    total;
    int    total_sat;
    logic  go;
    int    lat;
  } exp_t;

  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  int    m_total, m_total_sat;
  logic  m_go;
  grid_t m_prev;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: keep non-full rows in order, packed against the bottom.
  task automatic push_expected(input grid_t g);
    exp_t e;
    grid_t c = '0;
    int w = ROWS - 1;
    int n = 0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (&g[i]) n++;
      else begin
        c[w] = g[i];
        w--;
      end
    end
    m_total     = (m_total + n > 1023) ? 1023 : m_total + n;
    m_total_sat = (m_total_sat + n > 7) ? 7 : m_total_sat + n;
    m_go        = m_go | (|c[SPAWN_ROWS-1:0]);
    e.grid = c; e.lines = n; e.total = m_total; e.total_sat = m_total_sat;
    e.go = m_go; e.lat = ROWS + 1 + n;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_outputs();
    check("rst_grid_out", grid_out, '0);
    check("rst_lines", lines_cleared, 0);
    check("rst_total", total_lines, 0);
    check("rst_total_sat", total_lines_s, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_game_over", game_over, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    #1;
    check_reset_outputs();
    m_total = 0; m_total_sat = 0; m_go = 1'b0; m_prev = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_pass(input grid_t g, input bit mid_start);
    exp_t e;
    int cyc;
    @(negedge clk);
    grid_in = g;
    start   = 1'b1;
    push_expected(g);
    @(posedge clk);
    cyc = 1;
    #1;
    check("busy_after_start", busy, 1);
    @(negedge clk);
    start   = 1'b0;
    grid_in = '1;
    while (!done && cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 5) begin
        check("grid_out_stable", grid_out, m_prev);
        check("done_low_mid", done, 0);
      end
      if (mid_start && cyc == 10) start = 1'b1;
      if (mid_start && cyc == 11) start = 1'b0;
    end
    check("done_seen", done, 1);
    e = sb_q.pop_front();
    check("latency", cyc, e.lat);
    check("lines_cleared", lines_cleared, e.lines);
    check("grid_out", grid_out, e.grid);
    check("total_lines", total_lines, e.total);
    check("total_lines_sat", total_lines_s, e.total_sat);
    check("game_over", game_over, e.go);
    check("busy_in_done", busy, 1);
    m_prev = e.grid;
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);
    check("idle_after", busy, 0);
    check("lines_held", lines_cleared, e.lines);
  endtask

  initial begin
    grid_t g;
    int seen;
    start   = 1'b0;
    grid_in = '0;
    do_reset();

    // Empty grid.
    run_pass('0, 1'b0);

    // Single bottom row full.
    g = '0; g[21] = '1; g[20] = 10'h001;
    run_pass(g, 1'b0);

    // Four adjacent full rows from a fresh reset.
    do_reset();
    g = '0; g[21] = '1; g[20] = '1; g[19] = '1; g[18] = '1; g[17] = 10'h3C0;
    run_pass(g, 1'b0);

    // Non-adjacent full rows with an ignored start mid-pass.
    g = '0; g[21] = '1; g[20] = 10'h001; g[19] = '1;
    run_pass(g, 1'b1);

    // Completely full grid.
    run_pass('1, 1'b0);

    // Reset ten cycles into a pass: no done, everything back to zero.
    @(negedge clk);
    grid_in = '0; grid_in[21] = '1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    do_reset();
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no_done_after_abort", seen, 0);
    check("idle_after_abort", busy, 0);

    // Clean pass after the abort.
    g = '0; g[21] = '1; g[20] = '1; g[19] = '1; g[18] = '1; g[17] = 10'h3C0;
    run_pass(g, 1'b0);

    // Spawn row left occupied: game over, then sticky across further passes.
    g = '0; g[0] = 10'h010; g[21] = '1;
    run_pass(g, 1'b0);
    check("row1_after_clear", grid_out[1], 10'h010);
    g = '0; g[21] = '1; g[20] = '1; g[19] = '1; g[18] = '1;
    run_pass(g, 1'b0);
    run_pass(g, 1'b0);
    run_pass('0, 1'b0);

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
